// File: rtl/fpu_issue_ctrl.sv
// FP issue control: per-register scoreboard plus a 4-deep writeback slot shifter.
// Define FPU_ISSUE_FWD_EN to let a consumer issue in its producer's writeback cycle.
module fpu_issue_ctrl (
  input  logic        clk,
  input  logic        rstn,
  input  logic        issue_valid,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic        use_rs1,
  input  logic        use_rs2,
  input  logic        reg_write,
  input  logic [1:0]  lat,
  input  logic        flush,
  output logic        stall,
  output logic        issue_fire,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [15:0] stall_cnt
);

  logic [2:0]  cnt_q [32];
  logic [2:0]  cnt_d [32];
  logic [3:0]  sv_q, sv_d;
  logic [4:0]  srd_q [4];
  logic [4:0]  srd_d [4];
  logic [15:0] scnt_q, scnt_d;

  logic       busy1, busy2;
  logic       raw, waw, port_hz;
  logic       wr;
  logic [2:0] lat1;

  assign lat1 = {1'b0, lat} + 3'd1;

`ifdef FPU_ISSUE_FWD_EN
  // Last countdown cycle is the writeback cycle, covered by the bypass.
  assign busy1 = cnt_q[rs1] > 3'd1;
  assign busy2 = cnt_q[rs2] > 3'd1;
`else
  assign busy1 = cnt_q[rs1] != 3'd0;
  assign busy2 = cnt_q[rs2] != 3'd0;
`endif

  assign raw = (use_rs1 & busy1) | (use_rs2 & busy2);
  assign waw = reg_write & (cnt_q[rd] != 3'd0);
  // Entry in slot lat+1 shifts into slot lat on this edge and would collide.
  assign port_hz = reg_write & (lat != 2'd3) & sv_q[lat1[1:0]];

  assign stall      = issue_valid & (raw | waw | port_hz);
  assign issue_fire = issue_valid & ~stall & ~flush;
  assign wr         = issue_fire & reg_write;

  assign wb_valid  = sv_q[0];
  assign wb_rd     = srd_q[0];
  assign stall_cnt = scnt_q;

  always_comb begin
    for (int i = 0; i < 32; i++) begin
      cnt_d[i] = (cnt_q[i] == 3'd0) ? 3'd0 : cnt_q[i] - 3'd1;
    end
    sv_d     = {1'b0, sv_q[3:1]};
    srd_d[0] = srd_q[1];
    srd_d[1] = srd_q[2];
    srd_d[2] = srd_q[3];
    srd_d[3] = 5'd0;
    if (wr) begin
      cnt_d[rd]  = lat1;
      sv_d[lat]  = 1'b1;
      srd_d[lat] = rd;
    end
    scnt_d = scnt_q;
    if (stall && scnt_q != 16'hFFFF) begin
      scnt_d = scnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < 32; i++) begin
        cnt_q[i] <= 3'd0;
      end
      for (int i = 0; i < 4; i++) begin
        srd_q[i] <= 5'd0;
      end
      sv_q   <= 4'd0;
      scnt_q <= 16'd0;
    end else begin
      for (int i = 0; i < 32; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      for (int i = 0; i < 4; i++) begin
        srd_q[i] <= srd_d[i];
      end
      sv_q   <= sv_d;
      scnt_q <= scnt_d;
    end
  end

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Bench for fpu_issue_ctrl: directed scenarios plus random traffic
// checked against a pending-writeback list model.
module tb_fpu_issue_ctrl;

  logic        clk = 1'b0;
  logic        rstn;
  logic        issue_valid, use_rs1, use_rs2, reg_write, flush;
  logic [4:0]  rd, rs1, rs2;
  logic [1:0]  lat;
  logic        stall, issue_fire, wb_valid;
  logic [4:0]  wb_rd;
  logic [15:0] stall_cnt;

  int n_chk = 0;
  int n_err = 0;

  // Model: each accepted write is a (register, due cycle) pair.
  typedef struct {
    int rd;
    int due;
  } pend_t;

  pend_t pq[$];
  int    now  = 0;
  int    scnt = 0;

  always #5 clk = ~clk;

  fpu_issue_ctrl dut (
    .clk        (clk),
    .rstn       (rstn),
    .issue_valid(issue_valid),
    .rd         (rd),
    .rs1        (rs1),
    .rs2        (rs2),
    .use_rs1    (use_rs1),
    .use_rs2    (use_rs2),
    .reg_write  (reg_write),
    .lat        (lat),
    .flush      (flush),
    .stall      (stall),
    .issue_fire (issue_fire),
    .wb_valid   (wb_valid),
    .wb_rd      (wb_rd),
    .stall_cnt  (stall_cnt)
  );

  task automatic check(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)",
               tag, obs, exp, now);
    end
  endtask

  task automatic drive(input bit v, input int d, input int a,
                       input int b, input bit ua, input bit ub,
                       input bit w, input int l, input bit f);
    issue_valid = v;
    rd          = 5'(d);
    rs1         = 5'(a);
    rs2         = 5'(b);
    use_rs1     = ua;
    use_rs2     = ub;
    reg_write   = w;
    lat         = 2'(l);
    flush       = f;
  endtask

  task automatic idle();
    drive(1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
  endtask

  function automatic bit m_busy(int r);
    foreach (pq[i]) begin
      if (pq[i].rd == r) begin
`ifdef FPU_ISSUE_FWD_EN
        if (pq[i].due > now) return 1'b1;
`else
        if (pq[i].due >= now) return 1'b1;
`endif
      end
    end
    return 1'b0;
  endfunction

  function automatic bit m_stall();
    bit raw, waw, prt;
    if (!issue_valid) return 1'b0;
    raw = (use_rs1 && m_busy(int'(rs1))) ||
          (use_rs2 && m_busy(int'(rs2)));
    waw = 1'b0;
    prt = 1'b0;
    if (reg_write) begin
      foreach (pq[i]) begin
        if (pq[i].rd == int'(rd)) waw = 1'b1;
        if (pq[i].due == now + int'(lat) + 1) prt = 1'b1;
      end
    end
    return raw || waw || prt;
  endfunction

  task automatic purge();
    for (int i = pq.size() - 1; i >= 0; i--) begin
      if (pq[i].due < now) pq.delete(i);
    end
  endtask

  task automatic step(input bit chk);
    bit    es, ef, ev;
    int    erd;
    pend_t p;
    @(negedge clk);
    es  = m_stall();
    ef  = issue_valid && !es && !flush;
    ev  = 1'b0;
    erd = 0;
    foreach (pq[i]) begin
      if (pq[i].due == now) begin
        ev  = 1'b1;
        erd = pq[i].rd;
      end
    end
    if (chk) begin
      check("stall", stall, es);
      check("issue_fire", issue_fire, ef);
      check("wb_valid", wb_valid, ev);
      check("wb_rd", wb_rd, erd);
      check("stall_cnt", stall_cnt, scnt);
    end
    if (ef && reg_write) begin
      p.rd  = int'(rd);
      p.due = now + int'(lat) + 1;
      pq.push_back(p);
    end
    if (es && scnt < 65535) scnt++;
    @(posedge clk);
    #1;
    now++;
    purge();
  endtask

  initial begin
    int s3;
    int guard;
    rstn = 1'b0;
    idle();
    #2;
    check("rst_wb_valid", wb_valid, 0);
    check("rst_wb_rd", wb_rd, 0);
    check("rst_stall_cnt", stall_cnt, 0);
    check("rst_stall", stall, 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    repeat (3) step(1'b1);

    // lat=1 producer: writeback appears in cycle 2 only
    drive(1'b1, 5, 0, 0, 1'b0, 1'b0, 1'b1, 1, 1'b0);
    #1;
    check("d30_fire", issue_fire, 1);
    step(1'b1);
    drive(1'b1, 0, 5, 0, 1'b1, 1'b0, 1'b0, 0, 1'b0);
    #1;
    check("d30_c1_cnt_busy", stall, 1);
    check("d30_c1_wb", wb_valid, 0);
    step(1'b1);
    idle();
    #1;
    check("d30_c2_wb", wb_valid, 1);
    check("d30_c2_rd", wb_rd, 5);
    step(1'b1);
    check("d30_c3_wb", wb_valid, 0);
    repeat (4) step(1'b1);

    // RAW consumer behind lat=2 producer
`ifdef FPU_ISSUE_FWD_EN
    s3 = 0;
`else
    s3 = 1;
`endif
    drive(1'b1, 3, 0, 0, 1'b0, 1'b0, 1'b1, 2, 1'b0);
    #1;
    check("d31_prod_fire", issue_fire, 1);
    step(1'b1);
    drive(1'b1, 0, 3, 0, 1'b1, 1'b0, 1'b0, 0, 1'b0);
    for (int c = 1; c <= 4; c++) begin
      int es;
      es = (c <= 2) ? 1 : (c == 3) ? s3 : 0;
      #1;
      check($sformatf("d31_stall_c%0d", c), stall, es);
      check($sformatf("d31_fire_c%0d", c), issue_fire, 1 - es);
      step(1'b1);
    end
    idle();
    repeat (4) step(1'b1);

    // writeback port conflict
    drive(1'b1, 1, 0, 0, 1'b0, 1'b0, 1'b1, 2, 1'b0);
    step(1'b1);
    idle();
    step(1'b1);
    drive(1'b1, 2, 0, 0, 1'b0, 1'b0, 1'b1, 0, 1'b0);
    #1;
    check("d32_c2_stall", stall, 1);
    step(1'b1);
    check("d32_c3_fire", issue_fire, 1);
    check("d32_c3_wb", wb_valid, 1);
    check("d32_c3_rd", wb_rd, 1);
    step(1'b1);
    idle();
    #1;
    check("d32_c4_wb", wb_valid, 1);
    check("d32_c4_rd", wb_rd, 2);
    repeat (4) step(1'b1);

    // fill all four slots, then a non-writing issue
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 10 + k, 0, 0, 1'b0, 1'b0, 1'b1, 3, 1'b0);
      step(1'b1);
    end
    drive(1'b1, 0, 0, 0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    #1;
    check("d33_fire", issue_fire, 1);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("d33_wb%0d", k), wb_valid, 1);
      check($sformatf("d33_rd%0d", k), wb_rd, 10 + k);
      step(1'b1);
      idle();
      #1;
    end
    check("d33_drained", wb_valid, 0);
    repeat (2) step(1'b1);

    // flush blocks issue but not drain
    drive(1'b1, 20, 0, 0, 1'b0, 1'b0, 1'b1, 2, 1'b0);
    step(1'b1);
    drive(1'b1, 21, 0, 0, 1'b0, 1'b0, 1'b1, 3, 1'b1);
    #1;
    check("d34_fire", issue_fire, 0);
    check("d34_stall", stall, 0);
    step(1'b1);
    idle();
    step(1'b1);
    check("d34_wb", wb_valid, 1);
    check("d34_rd", wb_rd, 20);
    repeat (5) step(1'b1);

    // reset with two writebacks pending
    drive(1'b1, 8, 0, 0, 1'b0, 1'b0, 1'b1, 3, 1'b0);
    step(1'b1);
    drive(1'b1, 9, 0, 0, 1'b0, 1'b0, 1'b1, 3, 1'b0);
    step(1'b1);
    idle();
    rstn = 1'b0;
    #2;
    check("d35_rst_wb", wb_valid, 0);
    check("d35_rst_scnt", stall_cnt, 0);
    pq.delete();
    scnt = 0;
    @(posedge clk);
    #1;
    rstn = 1'b1;
    now++;
    for (int k = 0; k < 6; k++) begin
      check($sformatf("d35_post_wb%0d", k), wb_valid, 0);
      step(1'b1);
    end

    // random traffic
    for (int k = 0; k < 2000; k++) begin
      drive($urandom % 4 != 0, int'($urandom % 8), int'($urandom % 8),
            int'($urandom % 8), 1'($urandom % 2), 1'($urandom % 2),
            $urandom % 4 != 0, int'($urandom % 4), $urandom % 8 == 0);
      step(1'b1);
    end

    // saturate stall_cnt with a repeating WAW stall
    drive(1'b1, 7, 0, 0, 1'b0, 1'b0, 1'b1, 3, 1'b0);
    guard = 0;
    while (scnt < 65535 && guard < 90000) begin
      step(1'b0);
      guard++;
    end
    check("sat_bound", int'(guard < 90000), 1);
    repeat (10) step(1'b1);
    check("sat_ffff", stall_cnt, 65535);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/fpu_issue_ctrl.md
FPU_ISSUE_CTRL -- requirements
Module: fpu_issue_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, rising edge; one clock domain only.
REQ-002 SHALL have ports: rstn  in  1  reset, asynchronous assert, active-low.
REQ-003 SHALL have ports: issue_valid  in  1  decoded FP instruction presented for issue.
REQ-004 SHALL have ports: rd, rs1, rs2  in  5 each  FP register indices.
REQ-005 SHALL have ports: use_rs1, use_rs2, reg_write  in  1 each  operand-use and FP-writeback flags from decode.
REQ-006 SHALL have ports: lat  in  2  extra execute cycles; 0..3, from decode hazard class.
REQ-007 SHALL have ports: flush  in  1  suppress issue this cycle.
REQ-008 SHALL have ports: stall  out  1  issue blocked by a hazard (combinational).
REQ-009 SHALL have ports: issue_fire  out  1  instruction accepted this cycle (combinational).
REQ-010 SHALL have ports: wb_valid  out  1  FP register written this cycle (registered).
REQ-011 SHALL have ports: wb_rd  out  5  destination being written (registered).
REQ-012 SHALL have ports: stall_cnt  out  16  saturating count of stalled cycles.

Function
REQ-013 SHALL keep a per-register countdown cnt[0..31], 3 bits each; every nonzero cnt decrements by 1 per clock.
REQ-014 SHALL keep a 4-entry writeback slot shift register slot[0..3] of {valid, rd}; each clock slot[i] <= slot[i+1], and slot[3] is refilled invalid.
REQ-015 SHALL drive wb_valid/wb_rd from slot[0].
REQ-016 SHALL flag a RAW hazard when (use_rs1 and busy(rs1)) or (use_rs2 and busy(rs2)); busy per REQ-029.
REQ-017 SHALL flag a WAW hazard when reg_write and cnt[rd] != 0.
REQ-018 SHALL flag a port hazard when reg_write, lat < 3 and slot[lat+1].valid.
REQ-019 SHALL drive stall = issue_valid and (RAW or WAW or port hazard), independent of flush.
REQ-020 SHALL drive issue_fire = issue_valid and not stall and not flush.
REQ-021 SHALL, on an issue_fire with reg_write, load cnt[rd] <= lat+1 and load slot[lat] <= {1, rd} in the same edge as the shift; the insert wins over the shifted-in value.
REQ-022 SHALL make a fired writeback visible on wb_valid exactly lat+1 cycles after the fire cycle.
REQ-023 SHALL, on an issue_fire without reg_write, not reserve a slot, not touch cnt, and skip the WAW and port checks.
REQ-024 SHALL use flush to block only new issue; in-flight slots and counters continue to drain unchanged.
REQ-025 SHALL increment stall_cnt on every cycle with stall=1, holding at 16'hFFFF.
REQ-026 SHALL guarantee at most one wb_valid per cycle; two in-flight entries never hold the same slot.

Reset
REQ-027 SHALL, while rstn=0, immediately clear all cnt, all slot entries, wb_valid=0, wb_rd=0 and stall_cnt=0.
REQ-028 SHALL, when reset lands mid-operation, discard in-flight writebacks, so no wb_valid appears after release until a new fire.

Configuration
REQ-029 SHALL, with macro FPU_ISSUE_FWD_EN defined, treat busy(r) as cnt[r] > 1, allowing a consumer to issue in the producer's writeback cycle through the bypass; without the macro, busy(r) is cnt[r] != 0.

Verification
REQ-030 SHALL cover the following: lat=1 fire with rd=5 in cycle 0 -> wb_valid=1, wb_rd=5 in cycle 2 only; cnt[5]=2 in cycle 1.
REQ-031 SHALL cover the following: producer rd=3, lat=2 in cycle 0; consumer rs1=3 in cycle 1 -> stall in cycles 1-2, fire in cycle 3 with FPU_ISSUE_FWD_EN; stall through cycle 3, fire in cycle 4 without it.
REQ-032 SHALL cover the following: lat=2 fire rd=1 in cycle 0, then lat=0 fire rd=2 in cycle 2 -> port hazard stall in cycle 2; fire in cycle 3; wb rd=1 in cycle 3 and rd=2 in cycle 4.
REQ-033 SHALL cover the following: reg_write=0, use_rs1=0 issue while all slots are full -> issue_fire=1 and no slot change.
REQ-034 SHALL cover the following: flush=1 with a hazard-free issue -> issue_fire=0, stall=0, pending wb still emitted on time.
REQ-035 SHALL cover the following: rstn pulsed low for 1 cycle with 2 writebacks pending -> no wb_valid afterwards; hold stall for 70000 cycles -> stall_cnt=16'hFFFF.
